// File: rtl/i2c_sys_pkg.sv
//------------------------------------------------------------------------------
// i2c_sys_pkg: shared arbiter state encoding, requester ids, core register map
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package i2c_sys_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_GRANT0 = 2'd1,
    ARB_GRANT1 = 2'd2
  } arb_state_t;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  // Wishbone register map of the I2C master core (RXR/TXR and SR/CR share slots)
  localparam logic [2:0] PRER_LO = 3'h0;
  localparam logic [2:0] PRER_HI = 3'h1;
  localparam logic [2:0] CTR     = 3'h2;
  localparam logic [2:0] TXR     = 3'h3;
  localparam logic [2:0] RXR     = 3'h3;
  localparam logic [2:0] CR      = 3'h4;
  localparam logic [2:0] SR      = 3'h4;

endpackage

`default_nettype wire

// File: rtl/i2c_arb_wdog.sv
//------------------------------------------------------------------------------
// i2c_arb_wdog: grant-hold watchdog with one-cycle timeout pulse and blocked flags
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module i2c_arb_wdog
  import i2c_sys_pkg::*;
#(
  parameter int TIMEOUT_CYC = 4096,
  parameter int TW          = 12
) (
  input  logic clk,
  input  logic rst,
  input  logic grant0,
  input  logic grant1,
  input  logic req0,
  input  logic req1,
  output logic expire0,
  output logic expire1,
  output logic timeout,
  output logic blocked0,
  output logic blocked1
);

  localparam logic [TW-1:0] c_LAST = TW'(TIMEOUT_CYC - 1);

  logic [TW-1:0] r_cnt;
  logic          r_timeout;
  logic          r_blocked0;
  logic          r_blocked1;

  // Every grant is preceded by an IDLE cycle, so clearing in IDLE clears on entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (grant0 || grant1) begin
      r_cnt <= r_cnt + 1'b1;
    end else begin
      r_cnt <= '0;
    end
  end

  assign expire0 = grant0 && (r_cnt == c_LAST);
  assign expire1 = grant1 && (r_cnt == c_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_timeout  <= 1'b0;
      r_blocked0 <= 1'b0;
      r_blocked1 <= 1'b0;
    end else begin
      r_timeout <= expire0 || expire1;
      if (expire0)    r_blocked0 <= 1'b1;
      else if (!req0) r_blocked0 <= 1'b0;
      if (expire1)    r_blocked1 <= 1'b1;
      else if (!req1) r_blocked1 <= 1'b0;
    end
  end

  assign timeout  = r_timeout;
  assign blocked0 = r_blocked0;
  assign blocked1 = r_blocked1;

endmodule

`default_nettype wire

// File: rtl/i2c_wb_arbiter.sv
//------------------------------------------------------------------------------
// i2c_wb_arbiter: session-locked round-robin arbiter for the I2C core WB port
// Optional watchdog: define I2C_ARB_TIMEOUT_EN.  Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module i2c_wb_arbiter
  import i2c_sys_pkg::*;
#(
  parameter int TIMEOUT_CYC = 4096,
  parameter int TW          = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       req1,
  output logic       gnt0,
  output logic       gnt1,
  input  logic [2:0] m0_addr,
  input  logic [7:0] m0_wr_data,
  input  logic       m0_we,
  input  logic       m0_stb,
  input  logic       m0_cyc,
  output logic [7:0] m0_rd_data,
  output logic       m0_ack,
  output logic       m0_inta,
  input  logic [2:0] m1_addr,
  input  logic [7:0] m1_wr_data,
  input  logic       m1_we,
  input  logic       m1_stb,
  input  logic       m1_cyc,
  output logic [7:0] m1_rd_data,
  output logic       m1_ack,
  output logic       m1_inta,
  output logic [2:0] s_addr,
  output logic [7:0] s_wr_data,
  output logic       s_we,
  output logic       s_stb,
  output logic       s_cyc,
  input  logic [7:0] s_rd_data,
  input  logic       s_ack,
  input  logic       s_inta,
  output logic       busy,
  output logic       timeout
);

  arb_state_t r_state;
  arb_state_t w_state_nxt;
  logic       r_last;
  logic       w_last_nxt;
  logic       w_elig0;
  logic       w_elig1;
  logic       w_expire0;
  logic       w_expire1;

`ifdef I2C_ARB_TIMEOUT_EN
  logic w_blocked0;
  logic w_blocked1;

  i2c_arb_wdog #(
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .TW         (TW)
  ) u_wdog (
    .clk     (clk),
    .rst     (rst),
    .grant0  (gnt0),
    .grant1  (gnt1),
    .req0    (req0),
    .req1    (req1),
    .expire0 (w_expire0),
    .expire1 (w_expire1),
    .timeout (timeout),
    .blocked0(w_blocked0),
    .blocked1(w_blocked1)
  );

  assign w_elig0 = req0 && !w_blocked0;
  assign w_elig1 = req1 && !w_blocked1;
`else
  logic [31:0] w_unused_cfg;

  assign w_unused_cfg = 32'(TIMEOUT_CYC) ^ 32'(TW);
  assign w_elig0      = req0;
  assign w_elig1      = req1;
  assign w_expire0    = 1'b0;
  assign w_expire1    = 1'b0;
  assign timeout      = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ARB_IDLE;
      r_last  <= REQ1;
    end else begin
      r_state <= w_state_nxt;
      r_last  <= w_last_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_last_nxt  = r_last;
    s_addr      = 3'd0;
    s_wr_data   = 8'd0;
    s_we        = 1'b0;
    s_stb       = 1'b0;
    s_cyc       = 1'b0;
    m0_rd_data  = 8'd0;
    m0_ack      = 1'b0;
    m0_inta     = 1'b0;
    m1_rd_data  = 8'd0;
    m1_ack      = 1'b0;
    m1_inta     = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        if (w_elig0 && w_elig1) begin
          w_state_nxt = (r_last == REQ1) ? ARB_GRANT0 : ARB_GRANT1;
        end else if (w_elig0) begin
          w_state_nxt = ARB_GRANT0;
        end else if (w_elig1) begin
          w_state_nxt = ARB_GRANT1;
        end
      end
      ARB_GRANT0: begin
        s_addr     = m0_addr;
        s_wr_data  = m0_wr_data;
        s_we       = m0_we;
        s_stb      = m0_stb;
        s_cyc      = m0_cyc;
        m0_rd_data = s_rd_data;
        m0_ack     = s_ack;
        m0_inta    = s_inta;
        // An open bus cycle holds the grant; only the watchdog may cut it
        if (w_expire0 || (!req0 && !m0_cyc)) begin
          w_state_nxt = ARB_IDLE;
          w_last_nxt  = REQ0;
        end
      end
      ARB_GRANT1: begin
        s_addr     = m1_addr;
        s_wr_data  = m1_wr_data;
        s_we       = m1_we;
        s_stb      = m1_stb;
        s_cyc      = m1_cyc;
        m1_rd_data = s_rd_data;
        m1_ack     = s_ack;
        m1_inta    = s_inta;
        if (w_expire1 || (!req1 && !m1_cyc)) begin
          w_state_nxt = ARB_IDLE;
          w_last_nxt  = REQ1;
        end
      end
      default: w_state_nxt = ARB_IDLE;
    endcase
  end

  assign gnt0 = (r_state == ARB_GRANT0);
  assign gnt1 = (r_state == ARB_GRANT1);
  assign busy = gnt0 || gnt1;

endmodule

`default_nettype wire

// File: tb/tb_i2c_wb_arbiter.sv
//------------------------------------------------------------------------------
// tb_i2c_wb_arbiter: directed self-checking bench for i2c_wb_arbiter
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_i2c_wb_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, req1, gnt0, gnt1;
  logic [2:0] m0_addr, m1_addr, s_addr;
  logic [7:0] m0_wr_data, m1_wr_data, s_wr_data;
  logic       m0_we, m0_stb, m0_cyc, m1_we, m1_stb, m1_cyc;
  logic [7:0] m0_rd_data, m1_rd_data, s_rd_data;
  logic       m0_ack, m0_inta, m1_ack, m1_inta;
  logic       s_we, s_stb, s_cyc, s_ack, s_inta;
  logic       busy, timeout;

  int n_tests = 0;
  int n_fail  = 0;

  logic [13:0] sbus;
  logic [9:0]  m0_resp, m1_resp;
  logic [3:0]  rr_exp;

  assign sbus    = {s_addr, s_wr_data, s_we, s_stb, s_cyc};
  assign m0_resp = {m0_rd_data, m0_ack, m0_inta};
  assign m1_resp = {m1_rd_data, m1_ack, m1_inta};

  always #5 clk = ~clk;

  i2c_wb_arbiter #(
    .TIMEOUT_CYC(16),
    .TW         (5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req0      (req0),
    .req1      (req1),
    .gnt0      (gnt0),
    .gnt1      (gnt1),
    .m0_addr   (m0_addr),
    .m0_wr_data(m0_wr_data),
    .m0_we     (m0_we),
    .m0_stb    (m0_stb),
    .m0_cyc    (m0_cyc),
    .m0_rd_data(m0_rd_data),
    .m0_ack    (m0_ack),
    .m0_inta   (m0_inta),
    .m1_addr   (m1_addr),
    .m1_wr_data(m1_wr_data),
    .m1_we     (m1_we),
    .m1_stb    (m1_stb),
    .m1_cyc    (m1_cyc),
    .m1_rd_data(m1_rd_data),
    .m1_ack    (m1_ack),
    .m1_inta   (m1_inta),
    .s_addr    (s_addr),
    .s_wr_data (s_wr_data),
    .s_we      (s_we),
    .s_stb     (s_stb),
    .s_cyc     (s_cyc),
    .s_rd_data (s_rd_data),
    .s_ack     (s_ack),
    .s_inta    (s_inta),
    .busy      (busy),
    .timeout   (timeout)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_bus();
    m0_addr = 3'd0; m0_wr_data = 8'd0; m0_we = 1'b0; m0_stb = 1'b0; m0_cyc = 1'b0;
    m1_addr = 3'd0; m1_wr_data = 8'd0; m1_we = 1'b0; m1_stb = 1'b0; m1_cyc = 1'b0;
    s_rd_data = 8'd0; s_ack = 1'b0; s_inta = 1'b0;
  endtask

  initial begin
    logic tmo_seen, held;
    logic prev;
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    clr_bus();
    s_rd_data = 8'haa; s_ack = 1'b1; s_inta = 1'b1;
    #12;
    check("rst_gnt", {gnt1, gnt0}, 2'b00);
    check("rst_busy_tmo", {busy, timeout}, 2'b00);
    check("rst_sbus", sbus, 14'd0);
    check("rst_m0_resp", m0_resp, 10'd0);
    check("rst_m1_resp", m1_resp, 10'd0);
    step();
    rst = 1'b0;
    clr_bus();

    // single request from requester 0
    req0 = 1'b1; #1;
    check("single_pre_gnt", {gnt1, gnt0}, 2'b00);
    step();
    check("single_gnt0", {busy, gnt1, gnt0}, 3'b101);
    m0_addr = 3'b000; m0_wr_data = 8'hc8; m0_we = 1'b1; m0_stb = 1'b1; m0_cyc = 1'b1;
    m1_addr = 3'h7; m1_wr_data = 8'hff; m1_we = 1'b1; m1_stb = 1'b1; m1_cyc = 1'b1;
    s_rd_data = 8'h5a; s_ack = 1'b1; s_inta = 1'b1; #1;
    check("single_sbus", sbus, {3'b000, 8'hc8, 3'b111});
    check("single_m0_resp", m0_resp, {8'h5a, 2'b11});
    check("single_m1_iso", m1_resp, 10'd0);
    step();
    check("single_m1_iso2", m1_resp, 10'd0);
    clr_bus();
    s_rd_data = 8'h5a; s_ack = 1'b1; s_inta = 1'b1;
    req0 = 1'b0;
    step();
    check("single_release", {gnt1, gnt0}, 2'b00);
    check("idle_m0_resp", m0_resp, 10'd0);
    check("idle_sbus", sbus, 14'd0);
    clr_bus();

    // simultaneous request after reset: req0 wins, req1 two cycles after release
    rst = 1'b1; #1; rst = 1'b0;
    step();
    req0 = 1'b1; req1 = 1'b1;
    step();
    check("tie_first_gnt0", {gnt1, gnt0}, 2'b01);
    step(); step();
    req0 = 1'b0;
    step();
    check("tie_dead_cycle", {gnt1, gnt0}, 2'b00);
    step();
    check("tie_then_gnt1", {gnt1, gnt0}, 2'b10);

    // round-robin with both requesters re-requesting
    req0 = 1'b1;
    rr_exp = 4'b1010;
    prev = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("rr_not_both", {31'd0, gnt0 & gnt1}, 32'd0);
      if (prev) req1 = 1'b0; else req0 = 1'b0;
      step();
      check("rr_idle", {gnt1, gnt0}, 2'b00);
      if (prev) req1 = 1'b1; else req0 = 1'b1;
      step();
      check("rr_order", {gnt1, gnt0}, rr_exp[i] ? 2'b10 : 2'b01);
      prev = rr_exp[i];
    end

    // release while requester 1 has an open cycle
    m1_cyc = 1'b1; m1_stb = 1'b1; m1_addr = 3'h4; s_ack = 1'b0;
    req1 = 1'b0;
    step();
    check("open_hold_a", {gnt1, gnt0}, 2'b10);
    step();
    check("open_hold_b", {gnt1, gnt0}, 2'b10);
    s_ack = 1'b1; s_rd_data = 8'h81; #1;
    check("open_m1_ack", m1_resp, {8'h81, 2'b10});
    check("open_m0_iso", m0_resp, 10'd0);
    clr_bus();
    step();
    check("open_idle", {gnt1, gnt0}, 2'b00);
    step();
    check("open_next_gnt0", {gnt1, gnt0}, 2'b01);
    req0 = 1'b0;
    step();
    check("open_next_rel", {gnt1, gnt0}, 2'b00);

    // watchdog scenario
    req0 = 1'b1;
    step();
    check("wd_grant", {gnt1, gnt0}, 2'b01);
`ifdef I2C_ARB_TIMEOUT_EN
    for (int k = 1; k <= 15; k++) begin
      if (k == 5) req1 = 1'b1;
      step();
    end
    check("wd_pre", {timeout, gnt1, gnt0}, 3'b001);
    step();
    check("wd_revoke", {timeout, gnt1, gnt0}, 3'b100);
    step();
    check("wd_gnt1", {timeout, gnt1, gnt0}, 3'b010);
    req1 = 1'b0;
    step();
    check("wd_rel1", {gnt1, gnt0}, 2'b00);
    step();
    check("wd_blocked", {gnt1, gnt0}, 2'b00);
    req0 = 1'b0;
    step();
    check("wd_unblock_idle", {gnt1, gnt0}, 2'b00);
    req0 = 1'b1;
    step();
    check("wd_regrant", {gnt1, gnt0}, 2'b01);
    req0 = 1'b0;
    step();
    check("wd_final_rel", {gnt1, gnt0}, 2'b00);
`else
    tmo_seen = 1'b0;
    held     = 1'b1;
    for (int k = 1; k < 40; k++) begin
      if (k == 5) req1 = 1'b1;
      step();
      tmo_seen = tmo_seen | timeout;
      held     = held & gnt0;
    end
    check("nowd_timeout", {31'd0, tmo_seen}, 32'd0);
    check("nowd_held", {31'd0, held}, 32'd1);
    req0 = 1'b0;
    step();
    check("nowd_rel", {gnt1, gnt0}, 2'b00);
    step();
    check("nowd_gnt1", {gnt1, gnt0}, 2'b10);
    req1 = 1'b0;
    step();
    check("nowd_rel1", {gnt1, gnt0}, 2'b00);
`endif

    // asynchronous reset in the middle of a requester 1 session
    req0 = 1'b0; req1 = 1'b1;
    step();
    check("mid_gnt1", {gnt1, gnt0}, 2'b10);
    m1_cyc = 1'b1; m1_stb = 1'b1; m1_addr = 3'h5;
    s_ack = 1'b1; s_rd_data = 8'h33; s_inta = 1'b1; #1;
    check("mid_s_cyc", {31'd0, s_cyc}, 32'd1);
    #2;
    rst = 1'b1; #1;
    check("mid_rst_gnt", {busy, timeout, gnt1, gnt0}, 4'b0000);
    check("mid_rst_sbus", sbus, 14'd0);
    check("mid_rst_m1", m1_resp, 10'd0);
    check("mid_rst_m0", m0_resp, 10'd0);
    step();
    clr_bus();
    req0 = 1'b1; req1 = 1'b1;
    rst = 1'b0;
    step();
    check("post_rst_gnt0", {gnt1, gnt0}, 2'b01);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
